// File: rtl/decoder_seq_if.sv
// rtl/decoder_seq_if.sv - decoder input-bus sequencing interface
//
// Purpose: groups the M-cycle sequencing inputs and the decoder-facing
// outputs of decoder_seq into one bundle.
// Signals:
//   mcyc_ce       M-cycle advance enable (one CLK wide per M-cycle)
//   opcode_done   last M-cycle of the current instruction
//   din[7:0]      opcode byte fetched at an instruction boundary
//   intr_req      pending enabled interrupt
//   a[25:0]       complementary-pair decoder input vector
//   ir[7:0]       opcode register
//   state[2:0]    M-cycle counter
//   cb_mode       executing a CB-prefixed opcode
//   intr_dispatch executing the interrupt-dispatch pseudo-instruction
//   opcode_start  one-cycle pulse after a boundary update
//   seq_err       sticky state-counter overflow flag
// Modports: master drives the sequencing inputs; slave is the sequencer.
interface decoder_seq_if;
  logic        mcyc_ce;
  logic        opcode_done;
  logic [7:0]  din;
  logic        intr_req;
  logic [25:0] a;
  logic [7:0]  ir;
  logic [2:0]  state;
  logic        cb_mode;
  logic        intr_dispatch;
  logic        opcode_start;
  logic        seq_err;

  modport master (
    output mcyc_ce, opcode_done, din, intr_req,
    input  a, ir, state, cb_mode, intr_dispatch, opcode_start, seq_err
  );

  modport slave (
    input  mcyc_ce, opcode_done, din, intr_req,
    output a, ir, state, cb_mode, intr_dispatch, opcode_start, seq_err
  );
endinterface

// File: rtl/decoder_seq.sv
// rtl/decoder_seq.sv - instruction-boundary sequencer driving the decoder a-bus
//
// Purpose: holds the opcode register, CB-prefix flag, interrupt-dispatch
// flag and 3-bit M-cycle counter, and presents them to the decoder as a
// 26-bit vector of complementary bit pairs.
// Ports:
//   CLK    system clock, rising edge
//   RESET  asynchronous active-high reset
//   bus    decoder_seq_if.slave (sequencing inputs, decoder-facing outputs)
module decoder_seq (
  input  logic         CLK,
  input  logic         RESET,
  decoder_seq_if.slave bus
);

  logic [7:0]  ir_q;
  logic [2:0]  state_q;
  logic        cb_q;
  logic        intr_q;
  logic        start_q;
  logic        err_q;
  logic [12:0] true_bits;
  logic        cb_suffix_next;

  // A CB prefix is pending only when the opcode just finished was a plain
  // 0xCB; a CB-suffix 0xCB or a dispatch must not re-arm it.
  assign cb_suffix_next = (ir_q == 8'hCB) && !cb_q && !intr_q;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ir_q    <= 8'h00;
      state_q <= 3'd0;
      cb_q    <= 1'b0;
      intr_q  <= 1'b0;
      start_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      if (bus.mcyc_ce) begin
        if (bus.opcode_done) begin
          state_q <= 3'd0;
          // Guard keeps the pulse to a single cycle even if enables abut.
          start_q <= ~start_q;
          if (cb_suffix_next) begin
            cb_q   <= 1'b1;
            intr_q <= 1'b0;
            ir_q   <= bus.din;
          end else if (bus.intr_req) begin
            cb_q   <= 1'b0;
            intr_q <= 1'b1;
            ir_q   <= 8'h00;
          end else begin
            cb_q   <= 1'b0;
            intr_q <= 1'b0;
            ir_q   <= bus.din;
          end
        end else begin
          state_q <= state_q + 3'd1;
          if (state_q == 3'd7) begin
            err_q <= 1'b1;
          end
        end
      end
    end
  end

  // Pair k occupies a[2k+1] (true) and a[2k] (complement). Pair order from
  // the LSB: dispatch, cb, ir[7]..ir[0], state[2], state[1], state[0].
  assign true_bits = {state_q[0], state_q[1], state_q[2],
                      ir_q[0], ir_q[1], ir_q[2], ir_q[3],
                      ir_q[4], ir_q[5], ir_q[6], ir_q[7],
                      cb_q, intr_q};

  always_comb begin
    bus.a = '0;
    for (int k = 0; k < 13; k++) begin
      bus.a[2*k+1] = true_bits[k];
      bus.a[2*k]   = ~true_bits[k];
    end
  end

  assign bus.ir            = ir_q;
  assign bus.state         = state_q;
  assign bus.cb_mode       = cb_q;
  assign bus.intr_dispatch = intr_q;
  assign bus.opcode_start  = start_q;
  assign bus.seq_err       = err_q;

endmodule

// File: tb/tb_decoder_seq.sv
// tb/tb_decoder_seq.sv - self-checking bench for decoder_seq
module tb_decoder_seq;

  logic CLK;
  logic RESET;
  int   total;
  int   bad;

  decoder_seq_if bus ();

  decoder_seq dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus.slave)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference state
  logic [7:0] m_ir;
  logic [2:0] m_state;
  logic       m_cb;
  logic       m_intr;
  logic       m_start;
  logic       m_err;

  function automatic logic [25:0] exp_a(input logic [7:0] ir, input logic [2:0] st,
                                        input logic cb, input logic intr);
    logic [25:0] v;
    logic        t;
    v = '0;
    for (int k = 0; k < 13; k++) begin
      if (k == 0)      t = intr;
      else if (k == 1) t = cb;
      else if (k < 10) t = ir[9-k];
      else             t = st[12-k];
      v[2*k+1] = t;
      v[2*k]   = !t;
    end
    return v;
  endfunction

  task automatic model_reset();
    m_ir = 8'h00; m_state = 3'd0; m_cb = 1'b0; m_intr = 1'b0;
    m_start = 1'b0; m_err = 1'b0;
  endtask

  // Drives one clock with the given inputs, advances the model, and returns
  // at the following falling edge with inputs idle.
  task automatic step(input logic ce, input logic done, input logic [7:0] d, input logic irq);
    bus.mcyc_ce = ce; bus.opcode_done = done; bus.din = d; bus.intr_req = irq;
    @(posedge CLK);
    if (ce && done) begin
      m_start = 1'b1;
      m_state = 3'd0;
      if (m_ir == 8'hCB && !m_cb && !m_intr) begin
        m_cb = 1'b1; m_intr = 1'b0; m_ir = d;
      end else if (irq) begin
        m_cb = 1'b0; m_intr = 1'b1; m_ir = 8'h00;
      end else begin
        m_cb = 1'b0; m_intr = 1'b0; m_ir = d;
      end
    end else begin
      m_start = 1'b0;
      if (ce) begin
        if (m_state == 3'd7) m_err = 1'b1;
        m_state = (m_state + 3'd1) % 8;
      end
    end
    @(negedge CLK);
    bus.mcyc_ce = 1'b0; bus.opcode_done = 1'b0; bus.intr_req = 1'b0;
  endtask

  task automatic boundary(input logic [7:0] d, input logic irq);
    step(1'b1, 1'b1, d, irq);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic hw_reset();
    @(negedge CLK);
    RESET = 1'b1;
    #2;
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
  endtask

  task automatic test_reset();
    RESET = 1'b1;
    bus.mcyc_ce = 1'b0; bus.opcode_done = 1'b0; bus.din = 8'h00; bus.intr_req = 1'b0;
    model_reset();
    #2;
    total++;
    if (bus.a !== 26'h1555555) begin bad++; $display("FAIL reset_a got=%h exp=%h", bus.a, 26'h1555555); end
    total++;
    if ({bus.ir, bus.state, bus.cb_mode, bus.intr_dispatch, bus.opcode_start, bus.seq_err} !== 15'd0) begin
      bad++;
      $display("FAIL reset_regs got ir=%h st=%0d cb=%b int=%b start=%b err=%b exp all zero",
               bus.ir, bus.state, bus.cb_mode, bus.intr_dispatch, bus.opcode_start, bus.seq_err);
    end
    @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
  endtask

  task automatic test_load_step();
    boundary(8'h3E, 1'b0);
    total++;
    if (bus.ir !== 8'h3E || bus.state !== 3'd0 || bus.opcode_start !== 1'b1) begin
      bad++; $display("FAIL load got ir=%h st=%0d start=%b exp ir=3e st=0 start=1", bus.ir, bus.state, bus.opcode_start);
    end
    step(1'b1, 1'b0, 8'h00, 1'b0);
    total++;
    if (bus.opcode_start !== 1'b0) begin bad++; $display("FAIL start_pulse got=%b exp=0", bus.opcode_start); end
    idle();
    step(1'b1, 1'b0, 8'h00, 1'b0);
    total++;
    if (bus.state !== 3'd2 || bus.a !== 26'h196AA55) begin
      bad++; $display("FAIL step2 got st=%0d a=%h exp st=2 a=196aa55", bus.state, bus.a);
    end
  endtask

  task automatic test_cb_prefix();
    boundary(8'hCB, 1'b0);
    idle();
    boundary(8'h37, 1'b0);
    total++;
    if (bus.cb_mode !== 1'b1 || bus.a[3:2] !== 2'b10 || bus.ir !== 8'h37) begin
      bad++; $display("FAIL cb_suffix got cb=%b a32=%b ir=%h exp cb=1 a32=10 ir=37", bus.cb_mode, bus.a[3:2], bus.ir);
    end
    idle();
    boundary(8'h00, 1'b0);
    total++;
    if (bus.cb_mode !== 1'b0) begin bad++; $display("FAIL cb_clear got=%b exp=0", bus.cb_mode); end
    // A CB-suffix opcode of 0xCB must not arm another prefix.
    boundary(8'hCB, 1'b0);
    idle();
    boundary(8'hCB, 1'b0);
    idle();
    boundary(8'h44, 1'b0);
    total++;
    if (bus.cb_mode !== 1'b0 || bus.ir !== 8'h44) begin
      bad++; $display("FAIL cb_no_rearm got cb=%b ir=%h exp cb=0 ir=44", bus.cb_mode, bus.ir);
    end
  endtask

  task automatic test_interrupt();
    hw_reset();
    boundary(8'h55, 1'b1);
    total++;
    if (bus.intr_dispatch !== 1'b1 || bus.a[1:0] !== 2'b10 || bus.ir !== 8'h00) begin
      bad++; $display("FAIL intr_take got int=%b a10=%b ir=%h exp int=1 a10=10 ir=00", bus.intr_dispatch, bus.a[1:0], bus.ir);
    end
    idle();
    boundary(8'hCB, 1'b0);
    total++;
    if (bus.ir !== 8'hCB || bus.cb_mode !== 1'b0 || bus.intr_dispatch !== 1'b0) begin
      bad++; $display("FAIL intr_then_cb got ir=%h cb=%b int=%b exp ir=cb cb=0 int=0", bus.ir, bus.cb_mode, bus.intr_dispatch);
    end
    idle();
    boundary(8'h12, 1'b1);
    total++;
    if (bus.cb_mode !== 1'b1 || bus.intr_dispatch !== 1'b0 || bus.ir !== 8'h12) begin
      bad++; $display("FAIL cb_blocks_intr got cb=%b int=%b ir=%h exp cb=1 int=0 ir=12", bus.cb_mode, bus.intr_dispatch, bus.ir);
    end
  endtask

  task automatic test_overflow();
    hw_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 8'h00, 1'b0);
      if (i == 6) begin
        total++;
        if (bus.seq_err !== 1'b0) begin bad++; $display("FAIL err_early got=%b exp=0", bus.seq_err); end
      end
      idle();
    end
    total++;
    if (bus.state !== 3'd0 || bus.seq_err !== 1'b1) begin
      bad++; $display("FAIL overflow got st=%0d err=%b exp st=0 err=1", bus.state, bus.seq_err);
    end
    boundary(8'h21, 1'b0);
    idle();
    boundary(8'h22, 1'b1);
    total++;
    if (bus.seq_err !== 1'b1) begin bad++; $display("FAIL err_sticky got=%b exp=1", bus.seq_err); end
  endtask

  task automatic test_async_reset();
    hw_reset();
    boundary(8'hCB, 1'b0);
    idle();
    boundary(8'h37, 1'b0);
    for (int i = 0; i < 3; i++) begin
      idle();
      step(1'b1, 1'b0, 8'h00, 1'b0);
    end
    total++;
    if (bus.state !== 3'd3 || bus.cb_mode !== 1'b1) begin
      bad++; $display("FAIL pre_reset got st=%0d cb=%b exp st=3 cb=1", bus.state, bus.cb_mode);
    end
    #2;
    RESET = 1'b1;
    #1;
    total++;
    if (bus.a !== 26'h1555555 || bus.state !== 3'd0 || bus.cb_mode !== 1'b0 || bus.ir !== 8'h00) begin
      bad++; $display("FAIL async_reset got a=%h st=%0d cb=%b ir=%h exp a=1555555 st=0 cb=0 ir=00",
                      bus.a, bus.state, bus.cb_mode, bus.ir);
    end
    bus.mcyc_ce = 1'b1; bus.opcode_done = 1'b0;
    @(posedge CLK);
    #1;
    total++;
    if (bus.state !== 3'd0) begin bad++; $display("FAIL ce_in_reset got st=%0d exp=0", bus.state); end
    bus.mcyc_ce = 1'b0;
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
  endtask

  task automatic test_random();
    logic       prev_ce;
    logic       ce;
    logic       done;
    logic [7:0] d;
    hw_reset();
    prev_ce = 1'b0;
    for (int i = 0; i < 400; i++) begin
      ce   = prev_ce ? 1'b0 : ($urandom_range(0, 2) != 0);
      done = ($urandom_range(0, 3) == 0);
      d    = ($urandom_range(0, 3) == 0) ? 8'hCB : 8'($urandom);
      step(ce, done, d, ($urandom_range(0, 4) == 0));
      prev_ce = ce;
      total++;
      if (bus.ir !== m_ir || bus.state !== m_state || bus.cb_mode !== m_cb || bus.intr_dispatch !== m_intr ||
          bus.opcode_start !== m_start || bus.seq_err !== m_err ||
          bus.a !== exp_a(m_ir, m_state, m_cb, m_intr)) begin
        bad++;
        $display("FAIL random[%0d] got ir=%h st=%0d cb=%b int=%b start=%b err=%b a=%h exp ir=%h st=%0d cb=%b int=%b start=%b err=%b a=%h",
                 i, bus.ir, bus.state, bus.cb_mode, bus.intr_dispatch, bus.opcode_start, bus.seq_err, bus.a,
                 m_ir, m_state, m_cb, m_intr, m_start, m_err, exp_a(m_ir, m_state, m_cb, m_intr));
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_load_step();
    test_cb_prefix();
    test_interrupt();
    test_overflow();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decoder_seq.md
Name: decoder_seq

Overview:
- Producer side of the instruction decoder input bus.
- Holds the opcode register, the CB-prefix flag, the interrupt-dispatch flag and the 3-bit M-cycle state counter.
- Drives the 26-bit complementary-pair vector `a[25:0]` that Decoder1 consumes.
- Replaces the counter-driven stimulus with real instruction-boundary sequencing driven by M-cycle enables and the decoder's end-of-opcode indication.

Parameters:
- None. All widths are fixed by the decoder interface: 26-bit a-bus, 8-bit IR, 3-bit state.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- mcyc_ce  input  1  M-cycle advance enable, one CLK wide per M-cycle.
- opcode_done  input  1  last M-cycle of the current instruction; sampled only when mcyc_ce=1.
- din  input  8  opcode byte fetched on the data bus; valid when mcyc_ce=1 and opcode_done=1.
- intr_req  input  1  pending, enabled interrupt; sampled at instruction boundaries only.
- a  output  26  decoder input vector (mapping below).
- ir  output  8  current opcode register.
- state  output  3  M-cycle counter {state2,state1,state0}.
- cb_mode  output  1  executing a CB-prefixed opcode.
- intr_dispatch  output  1  executing the interrupt-dispatch pseudo-instruction.
- opcode_start  output  1  one-CLK pulse in the cycle after a boundary update.
- seq_err  output  1  sticky flag: state counter overflowed without opcode_done.

Behaviour:
- Asynchronous reset, while RESET=1 regardless of CLK:
  - ir=0x00, state=0, cb_mode=0, intr_dispatch=0, opcode_start=0, seq_err=0.
  - Internal prev_cb=0.
  - Therefore a=0x1555555.
  - Assertion mid-instruction clears everything immediately.
  - First update after release needs a CLK edge with mcyc_ce=1.
- a mapping:
  - Combinational from registers only; no input feeds `a` directly.
  - a[1]=intr_dispatch, a[0]=~a[1].
  - a[3]=cb_mode, a[2]=~a[3].
  - a[5]=ir[7], a[7]=ir[6], a[9]=ir[5], a[11]=ir[4], a[13]=ir[3], a[15]=ir[2], a[17]=ir[1], a[19]=ir[0].
  - Each even bit a[2k] = ~a[2k+1] for k=2..9.
  - a[21]=state[2], a[23]=state[1], a[25]=state[0]; a[20], a[22], a[24] are their complements.
- mcyc_ce=0: every register holds; opcode_start=0.
- mcyc_ce=1, opcode_done=0:
  - state <= state+1 (mod 8).
  - If the old state was 7, state wraps to 0 and seq_err <= 1.
  - ir, cb_mode and intr_dispatch hold.
- mcyc_ce=1, opcode_done=1 (instruction boundary): state <= 0 and opcode_start <= 1 next cycle. Priority order:
  1. CB suffix: if ir==0xCB, cb_mode==0 and intr_dispatch==0, then cb_mode <= 1, intr_dispatch <= 0, ir <= din. intr_req is ignored; no interrupt is taken between the prefix and its suffix.
  2. Else if intr_req=1: intr_dispatch <= 1, cb_mode <= 0, ir <= 0x00. din is discarded.
  3. Else: cb_mode <= 0, intr_dispatch <= 0, ir <= din.
- A completed CB-suffix instruction with suffix byte 0xCB does not re-arm the prefix, because the cb_mode==1 check blocks it.
- A dispatch boundary followed by din=0xCB at the next boundary loads 0xCB normally (rule 3).
- seq_err is cleared only by RESET.
- opcode_start is registered and is never asserted for two consecutive cycles.
- Latency:
  - Inputs reach ir/state/flags at the next CLK edge.
  - `a` reflects them in the same cycle as the register update, with zero additional delay.

Test Plan:
- Reset: assert RESET with no CLK edge → a=0x1555555, ir=0x00, state=0, all flags 0.
- Load and step:
  - Boundary with din=0x3E → ir=0x3E, state=0, opcode_start=1 for one cycle.
  - Then two ce without done → state=2, a=0x196AA55.
- CB prefix:
  - Boundary with din=0xCB, then boundary with din=0x37 → cb_mode=1, a[3]=1, a[2]=0, ir=0x37.
  - Then boundary with din=0x00 → cb_mode=0.
- Interrupt:
  - Boundary with intr_req=1 and ir=0x00 → intr_dispatch=1, a[1]=1, ir=0x00.
  - Boundary with intr_req=1 and ir=0xCB, cb_mode=0 → cb_mode=1, intr_dispatch=0, ir=din.
- Overflow: from state=0, eight ce pulses with opcode_done=0 → state=0, seq_err=1; seq_err persists across later boundaries.
- Async reset mid-op: state=3, cb_mode=1, assert RESET between edges → outputs return to reset values before the next CLK edge; mcyc_ce ignored while RESET=1.
